// File: rtl/ctrl_pkg.sv
// Shared encodings for the single-cycle RV32I-subset controller: opcodes,
// control-field codes, the packed control word and the sequencer states.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [2:0] F3_JALR   = 3'b000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_ctl_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  typedef struct packed {
    res_src_t res_src;
    pc_src_t  pc_src;
    alu_op_t  alu_op;
    logic     reg_wr;
    logic     mem_wr;
    imm_ctl_t imm_ctl;
    logic     alu_src_b;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '{
    res_src:   RES_ALU,
    pc_src:    PC_PLUS4,
    alu_op:    ALU_ADD,
    reg_wr:    1'b0,
    mem_wr:    1'b0,
    imm_ctl:   IMM_I,
    alu_src_b: 1'b0
  };

  function automatic logic alu_f3_legal(input logic [2:0] f3);
    return (f3 == F3_ADDSUB) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
           (f3 == F3_OR) || (f3 == F3_AND);
  endfunction

  // The SUB selector only matters for f3=000; I-type callers pass 0.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic sub);
    alu_op_t op;
    case (f3)
      F3_ADDSUB: op = sub ? ALU_SUB : ALU_ADD;
      F3_AND:    op = ALU_AND;
      F3_OR:     op = ALU_OR;
      F3_XOR:    op = ALU_XOR;
      F3_SLT:    op = ALU_SLT;
      default:   op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational instruction decoder producing the datapath control
// word and flagging stop (ecall or illegal) instructions.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       f7_bit6,
  input  logic       zero,
  output ctrl_word_t ctrl,
  output logic       is_stop,
  output logic       is_illegal
);

  always_comb begin
    ctrl       = CTRL_NOP;
    is_stop    = 1'b0;
    is_illegal = 1'b0;

    case (opcode)
      OP_R: begin
        if (alu_f3_legal(f3)) begin
          ctrl.alu_op = alu_from_f3(f3, f7_bit6);
          ctrl.reg_wr = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end

      OP_I: begin
        if (alu_f3_legal(f3)) begin
          ctrl.alu_op    = alu_from_f3(f3, 1'b0);
          ctrl.alu_src_b = 1'b1;
          ctrl.reg_wr    = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end

      OP_LOAD: begin
        if (f3 == F3_WORD) begin
          ctrl.alu_src_b = 1'b1;
          ctrl.res_src   = RES_MEM;
          ctrl.reg_wr    = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end

      OP_STORE: begin
        if (f3 == F3_WORD) begin
          ctrl.alu_src_b = 1'b1;
          ctrl.imm_ctl   = IMM_S;
          ctrl.mem_wr    = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end

      // Branch compares via SUB; the ALU zero flag picks the target.
      OP_BRANCH: begin
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          ctrl.alu_op  = ALU_SUB;
          ctrl.imm_ctl = IMM_B;
          if ((f3 == F3_BEQ) ? zero : ~zero)
            ctrl.pc_src = PC_IMM;
        end else begin
          is_illegal = 1'b1;
        end
      end

      OP_JAL: begin
        ctrl.imm_ctl = IMM_J;
        ctrl.pc_src  = PC_IMM;
        ctrl.res_src = RES_PC4;
        ctrl.reg_wr  = 1'b1;
      end

      OP_JALR: begin
        if (f3 == F3_JALR) begin
          ctrl.alu_src_b = 1'b1;
          ctrl.pc_src    = PC_ALU;
          ctrl.res_src   = RES_PC4;
          ctrl.reg_wr    = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end

      OP_SYSTEM: is_stop = 1'b1;

      default: is_illegal = 1'b1;
    endcase

    // Illegal encodings present an all-quiet control word.
    if (is_illegal) begin
      ctrl    = CTRL_NOP;
      is_stop = 1'b1;
    end
  end

endmodule

// File: rtl/single_cycle_ctrl.sv
// Run/step/pause/halt sequencer for the single-cycle datapath: gates the
// datapath clock-enable and write strobes, and keeps debug counters.
module single_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_f3,
  input  logic             i_f7_bit6,
  input  logic             i_zero,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_halt_req,
  output logic [1:0]       o_res_src,
  output logic [1:0]       o_pc_src,
  output logic [2:0]       o_alu_op,
  output logic             o_reg_wr,
  output logic             o_mem_wr,
  output logic [1:0]       o_imm_ctl,
  output logic             o_alu_src_b,
  output logic             o_clk_enable,
  output logic             o_halted,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_retired_cnt
);

  localparam state_t RESET_STATE = AUTO_RUN ? S_RUN : S_IDLE;

  ctrl_word_t ctrl;
  logic       is_stop;
  logic       is_illegal;
  state_t     state;
  logic       active;

  ctrl_decoder u_decoder (
    .opcode     (i_opcode),
    .f3         (i_f3),
    .f7_bit6    (i_f7_bit6),
    .zero       (i_zero),
    .ctrl       (ctrl),
    .is_stop    (is_stop),
    .is_illegal (is_illegal)
  );

  // Enable is combinational so a stop instruction never commits.
  assign active       = (state == S_RUN) || (state == S_STEP);
  assign o_clk_enable = active & ~is_stop & ~i_rst;

  assign o_res_src   = ctrl.res_src;
  assign o_pc_src    = ctrl.pc_src;
  assign o_alu_op    = ctrl.alu_op;
  assign o_imm_ctl   = ctrl.imm_ctl;
  assign o_alu_src_b = ctrl.alu_src_b;
  assign o_reg_wr    = ctrl.reg_wr & o_clk_enable;
  assign o_mem_wr    = ctrl.mem_wr & o_clk_enable;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= RESET_STATE;
      o_halted  <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_run)
            state <= S_RUN;
          else if (i_step)
            state <= S_STEP;
        end
        S_RUN: begin
          if (is_stop) begin
            state     <= S_HALT;
            o_halted  <= 1'b1;
            o_illegal <= is_illegal;
          end else if (i_halt_req || !i_run) begin
            state <= S_IDLE;
          end
        end
        S_STEP: begin
          if (is_stop) begin
            state     <= S_HALT;
            o_halted  <= 1'b1;
            o_illegal <= is_illegal;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Both counters track committed cycles; kept apart for multi-cycle reuse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cycle_cnt   <= '0;
      o_retired_cnt <= '0;
    end else if (o_clk_enable) begin
      o_cycle_cnt   <= o_cycle_cnt + CNT_W'(1);
      o_retired_cnt <= o_retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_single_cycle_ctrl.sv
// Self-checking bench for single_cycle_ctrl: directed scenarios plus a
// randomized run compared against an instruction-level reference model.
module tb_single_cycle_ctrl;

  localparam int CNT_W = 8;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [6:0]       i_opcode;
  logic [2:0]       i_f3;
  logic             i_f7_bit6;
  logic             i_zero;
  logic             i_run;
  logic             i_step;
  logic             i_halt_req;
  logic [1:0]       o_res_src;
  logic [1:0]       o_pc_src;
  logic [2:0]       o_alu_op;
  logic             o_reg_wr;
  logic             o_mem_wr;
  logic [1:0]       o_imm_ctl;
  logic             o_alu_src_b;
  logic             o_clk_enable;
  logic             o_halted;
  logic             o_illegal;
  logic [CNT_W-1:0] o_cycle_cnt;
  logic [CNT_W-1:0] o_retired_cnt;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  single_cycle_ctrl #(.CNT_W(CNT_W), .AUTO_RUN(1'b0)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_opcode      (i_opcode),
    .i_f3          (i_f3),
    .i_f7_bit6     (i_f7_bit6),
    .i_zero        (i_zero),
    .i_run         (i_run),
    .i_step        (i_step),
    .i_halt_req    (i_halt_req),
    .o_res_src     (o_res_src),
    .o_pc_src      (o_pc_src),
    .o_alu_op      (o_alu_op),
    .o_reg_wr      (o_reg_wr),
    .o_mem_wr      (o_mem_wr),
    .o_imm_ctl     (o_imm_ctl),
    .o_alu_src_b   (o_alu_src_b),
    .o_clk_enable  (o_clk_enable),
    .o_halted      (o_halted),
    .o_illegal     (o_illegal),
    .o_cycle_cnt   (o_cycle_cnt),
    .o_retired_cnt (o_retired_cnt)
  );

  // Reference model: instruction kinds and an abstract sequencer mode.
  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_JALR, K_ECALL, K_BAD} kind_t;
  typedef enum int {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;

  typedef struct packed {
    logic [1:0] res;
    logic [1:0] pc;
    logic [2:0] alu;
    logic       reg_wr;
    logic       mem_wr;
    logic [1:0] imm;
    logic       srcb;
    logic       stop;
    logic       illegal;
  } exp_t;

  mode_t       m_mode = M_IDLE;
  logic        m_illegal = 1'b0;
  int unsigned m_cycles = 0;
  int unsigned m_retired = 0;

  function automatic int alu_code(input logic [2:0] f3);
    case (f3)
      3'b000:  return 0;
      3'b111:  return 2;
      3'b110:  return 3;
      3'b100:  return 4;
      3'b010:  return 5;
      default: return -1;
    endcase
  endfunction

  function automatic kind_t classify(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      7'b0110011: return (alu_code(f3) >= 0) ? K_R : K_BAD;
      7'b0010011: return (alu_code(f3) >= 0) ? K_I : K_BAD;
      7'b0000011: return (f3 == 3'b010) ? K_LW : K_BAD;
      7'b0100011: return (f3 == 3'b010) ? K_SW : K_BAD;
      7'b1100011: return (f3 == 3'b000) ? K_BEQ : ((f3 == 3'b001) ? K_BNE : K_BAD);
      7'b1101111: return K_JAL;
      7'b1100111: return (f3 == 3'b000) ? K_JALR : K_BAD;
      7'b1110011: return K_ECALL;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic exp_t expect_decode(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic f7, input logic zero);
    exp_t e;
    e = '0;
    case (classify(opc, f3))
      K_R:     begin e.alu = (f3 == 3'b000 && f7) ? 3'd1 : 3'(alu_code(f3)); e.reg_wr = 1; end
      K_I:     begin e.alu = 3'(alu_code(f3)); e.srcb = 1; e.reg_wr = 1; end
      K_LW:    begin e.srcb = 1; e.res = 2'd1; e.reg_wr = 1; end
      K_SW:    begin e.srcb = 1; e.imm = 2'd1; e.mem_wr = 1; end
      K_BEQ:   begin e.alu = 3'd1; e.imm = 2'd2; e.pc = zero ? 2'd1 : 2'd0; end
      K_BNE:   begin e.alu = 3'd1; e.imm = 2'd2; e.pc = zero ? 2'd0 : 2'd1; end
      K_JAL:   begin e.imm = 2'd3; e.pc = 2'd1; e.res = 2'd2; e.reg_wr = 1; end
      K_JALR:  begin e.srcb = 1; e.pc = 2'd2; e.res = 2'd2; e.reg_wr = 1; end
      K_ECALL: e.stop = 1;
      default: begin e.stop = 1; e.illegal = 1; end
    endcase
    return e;
  endfunction

  function automatic logic expect_enable();
    exp_t e;
    e = expect_decode(i_opcode, i_f3, i_f7_bit6, i_zero);
    return !i_rst && (m_mode == M_RUN || m_mode == M_STEP) && !e.stop;
  endfunction

  task automatic drive(input logic rst, input logic run, input logic step, input logic halt,
                       input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic zero);
    @(negedge i_clk);
    i_rst = rst; i_run = run; i_step = step; i_halt_req = halt;
    i_opcode = opc; i_f3 = f3; i_f7_bit6 = f7; i_zero = zero;
    #2;
  endtask

  // Advance one clock edge and let the model consume the inputs of that cycle.
  task automatic tick();
    exp_t e;
    logic en;
    @(posedge i_clk);
    e  = expect_decode(i_opcode, i_f3, i_f7_bit6, i_zero);
    en = expect_enable();
    if (i_rst) begin
      m_mode = M_IDLE; m_illegal = 0; m_cycles = 0; m_retired = 0;
    end else begin
      if (en) begin
        m_cycles  = (m_cycles + 1) % (1 << CNT_W);
        m_retired = (m_retired + 1) % (1 << CNT_W);
      end
      case (m_mode)
        M_IDLE: if (i_run) m_mode = M_RUN; else if (i_step) m_mode = M_STEP;
        M_RUN:  if (e.stop) begin m_mode = M_HALT; m_illegal = e.illegal; end
                else if (i_halt_req || !i_run) m_mode = M_IDLE;
        M_STEP: if (e.stop) begin m_mode = M_HALT; m_illegal = e.illegal; end
                else m_mode = M_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 7'b0110011, 3'b000, 0, 0);
      total++;
      if (o_clk_enable !== 1'b0 || o_reg_wr !== 1'b0) begin
        bad++; $display("FAIL reset_gating en=%b reg_wr=%b expected 0/0", o_clk_enable, o_reg_wr);
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 7'b0110011, 3'b000, 0, 0);
      total++;
      if (o_clk_enable !== 1'b0 || o_cycle_cnt !== '0 || o_retired_cnt !== '0 || o_halted !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset en=%b cyc=%0d ret=%0d halted=%b expected 0/0/0/0",
                 o_clk_enable, o_cycle_cnt, o_retired_cnt, o_halted);
      end
      tick();
    end
  endtask

  task automatic test_r_type();
    drive(0, 1, 0, 0, 7'b0110011, 3'b000, 1, 0);
    total++;
    if (o_clk_enable !== 1'b0) begin
      bad++; $display("FAIL r_first_idle en=%b expected 0", o_clk_enable);
    end
    tick();
    drive(0, 1, 0, 0, 7'b0110011, 3'b000, 1, 0);
    total++;
    if (o_alu_op !== 3'b001 || o_reg_wr !== 1'b1 || o_res_src !== 2'b00 ||
        o_alu_src_b !== 1'b0 || o_clk_enable !== 1'b1) begin
      bad++;
      $display("FAIL r_sub alu=%b reg_wr=%b res=%b srcb=%b en=%b expected 001/1/00/0/1",
               o_alu_op, o_reg_wr, o_res_src, o_alu_src_b, o_clk_enable);
    end
    tick();
  endtask

  task automatic test_branches();
    logic [2:0] f3s [3] = '{3'b000, 3'b001, 3'b001};
    logic       zs  [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] pcs [3] = '{2'b01, 2'b00, 2'b01};
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 7'b1100011, f3s[i], 0, zs[i]);
      total++;
      if (o_pc_src !== pcs[i] || o_alu_op !== 3'b001 || o_imm_ctl !== 2'b10 || o_clk_enable !== 1'b1) begin
        bad++;
        $display("FAIL branch_%0d pc=%b alu=%b imm=%b en=%b expected %b/001/10/1",
                 i, o_pc_src, o_alu_op, o_imm_ctl, o_clk_enable, pcs[i]);
      end
      tick();
    end
  endtask

  task automatic test_step();
    drive(1, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
    tick();
    drive(0, 0, 1, 0, 7'b0010011, 3'b000, 0, 0);
    total++;
    if (o_clk_enable !== 1'b0) begin
      bad++; $display("FAIL step_request en=%b expected 0", o_clk_enable);
    end
    tick();
    drive(0, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
    total++;
    if (o_clk_enable !== 1'b1 || o_retired_cnt !== 8'd0) begin
      bad++; $display("FAIL step_exec en=%b ret=%0d expected 1/0", o_clk_enable, o_retired_cnt);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
      total++;
      if (o_clk_enable !== 1'b0 || o_retired_cnt !== 8'd1 || o_halted !== 1'b0) begin
        bad++;
        $display("FAIL step_done en=%b ret=%0d halted=%b expected 0/1/0",
                 o_clk_enable, o_retired_cnt, o_halted);
      end
      tick();
    end
  endtask

  task automatic test_ecall();
    logic [CNT_W-1:0] held;
    drive(0, 1, 0, 0, 7'b0010011, 3'b000, 0, 0);
    tick();
    drive(0, 1, 0, 0, 7'b1110011, 3'b000, 0, 0);
    total++;
    if (o_clk_enable !== 1'b0 || o_reg_wr !== 1'b0) begin
      bad++; $display("FAIL ecall_commit en=%b reg_wr=%b expected 0/0", o_clk_enable, o_reg_wr);
    end
    tick();
    held = CNT_W'(m_retired);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 7'b0010011, 3'b000, 0, 0);
      total++;
      if (o_halted !== 1'b1 || o_illegal !== 1'b0 || o_clk_enable !== 1'b0 || o_retired_cnt !== held) begin
        bad++;
        $display("FAIL ecall_halted halted=%b ill=%b en=%b ret=%0d expected 1/0/0/%0d",
                 o_halted, o_illegal, o_clk_enable, o_retired_cnt, held);
      end
      tick();
    end
  endtask

  task automatic test_illegal_halt_req();
    drive(1, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 7'b0010011, 3'b000, 0, 0);
      tick();
    end
    drive(0, 1, 0, 1, 7'b0000000, 3'b000, 0, 0);
    total++;
    if (o_clk_enable !== 1'b0) begin
      bad++; $display("FAIL illegal_commit en=%b expected 0", o_clk_enable);
    end
    tick();
    drive(0, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
    total++;
    if (o_halted !== 1'b1 || o_illegal !== 1'b1 || o_retired_cnt !== 8'd2) begin
      bad++;
      $display("FAIL illegal_halt halted=%b ill=%b ret=%0d expected 1/1/2", o_halted, o_illegal, o_retired_cnt);
    end
    tick();
    drive(1, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
    tick();
    drive(0, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
    total++;
    if (o_halted !== 1'b0 || o_illegal !== 1'b0 || o_cycle_cnt !== '0 ||
        o_retired_cnt !== '0 || o_clk_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_recover halted=%b ill=%b cyc=%0d ret=%0d en=%b expected 0/0/0/0/0",
               o_halted, o_illegal, o_cycle_cnt, o_retired_cnt, o_clk_enable);
    end
    tick();
  endtask

  task automatic test_wrap();
    drive(1, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
    tick();
    for (int i = 0; i < 261; i++) begin
      drive(0, 1, 0, 0, 7'b0010011, 3'b000, 0, 0);
      tick();
    end
    drive(0, 1, 0, 0, 7'b0010011, 3'b000, 0, 0);
    total++;
    if (o_cycle_cnt !== 8'd4 || o_retired_cnt !== 8'd4) begin
      bad++; $display("FAIL counter_wrap cyc=%0d ret=%0d expected 4/4", o_cycle_cnt, o_retired_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b1100111};
    logic [2:0] alu_f3s [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    logic [6:0] opc;
    logic [2:0] f3;
    exp_t e;
    logic en;
    int r;
    drive(1, 0, 0, 0, 7'b0010011, 3'b000, 0, 0);
    tick();
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 19));
      if (r < 18) opc = ops[r % 7];
      else if (r == 18) opc = 7'b1110011;
      else opc = 7'($urandom);
      case (opc)
        7'b0110011, 7'b0010011: f3 = alu_f3s[$urandom_range(0, 4)];
        7'b0000011, 7'b0100011: f3 = 3'b010;
        7'b1100011:             f3 = 3'($urandom_range(0, 1));
        default:                f3 = 3'b000;
      endcase
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, opc, f3, 1'($urandom), 1'($urandom));
      e  = expect_decode(i_opcode, i_f3, i_f7_bit6, i_zero);
      en = expect_enable();
      total++;
      if ({o_res_src, o_pc_src, o_alu_op, o_imm_ctl, o_alu_src_b} !== {e.res, e.pc, e.alu, e.imm, e.srcb}) begin
        bad++;
        $display("FAIL rnd_ctrl cyc=%0d op=%b f3=%b got=%h expected=%h", c, opc, f3,
                 {o_res_src, o_pc_src, o_alu_op, o_imm_ctl, o_alu_src_b}, {e.res, e.pc, e.alu, e.imm, e.srcb});
      end
      total++;
      if ({o_clk_enable, o_reg_wr, o_mem_wr} !== {en, e.reg_wr & en, e.mem_wr & en}) begin
        bad++;
        $display("FAIL rnd_enables cyc=%0d got=%b expected=%b", c,
                 {o_clk_enable, o_reg_wr, o_mem_wr}, {en, e.reg_wr & en, e.mem_wr & en});
      end
      total++;
      if ({o_halted, o_illegal} !== {m_mode == M_HALT, m_illegal}) begin
        bad++;
        $display("FAIL rnd_status cyc=%0d got=%b expected=%b", c, {o_halted, o_illegal},
                 {m_mode == M_HALT, m_illegal});
      end
      total++;
      if (o_cycle_cnt !== CNT_W'(m_cycles) || o_retired_cnt !== CNT_W'(m_retired)) begin
        bad++;
        $display("FAIL rnd_counts cyc=%0d got=%0d/%0d expected=%0d/%0d", c,
                 o_cycle_cnt, o_retired_cnt, m_cycles, m_retired);
      end
      tick();
    end
  endtask

  initial begin
    i_rst = 1; i_run = 0; i_step = 0; i_halt_req = 0;
    i_opcode = '0; i_f3 = '0; i_f7_bit6 = 0; i_zero = 0;
    test_reset();
    test_r_type();
    test_branches();
    test_step();
    test_ecall();
    test_illegal_halt_req();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
